// File: rtl/n64_pkg.sv
// Shared types and constants for the N64 controller poll engine.
// Response bit k is the k-th bit received from the controller.
package n64_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_BIT,
    ST_TX_STOP,
    ST_RX_WAIT_FALL,
    ST_RX_SAMPLE,
    ST_RX_WAIT_RISE,
    ST_DONE,
    ST_ABORT
  } n64_state_t;

  localparam logic [7:0] POLL_CMD  = 8'h01;
  localparam int         RESP_BITS = 32;

  localparam int BTN_A     = 11;
  localparam int BTN_B     = 10;
  localparam int BTN_Z     = 9;
  localparam int BTN_START = 8;
  localparam int BTN_DU    = 7;
  localparam int BTN_DD    = 6;
  localparam int BTN_DL    = 5;
  localparam int BTN_DR    = 4;
  localparam int BTN_L     = 3;
  localparam int BTN_R     = 2;
  localparam int BTN_CU    = 1;
  localparam int BTN_CD    = 0;

  localparam int RSP_A     = 0;
  localparam int RSP_B     = 1;
  localparam int RSP_Z     = 2;
  localparam int RSP_START = 3;
  localparam int RSP_DU    = 4;
  localparam int RSP_DD    = 5;
  localparam int RSP_DL    = 6;
  localparam int RSP_DR    = 7;
  localparam int RSP_L     = 10;
  localparam int RSP_R     = 11;
  localparam int RSP_CU    = 12;
  localparam int RSP_CD    = 13;

  function automatic logic [11:0] map_buttons(input logic [RESP_BITS-1:0] rsp);
    logic [11:0] b;
    b            = '0;
    b[BTN_A]     = rsp[RSP_A];
    b[BTN_B]     = rsp[RSP_B];
    b[BTN_Z]     = rsp[RSP_Z];
    b[BTN_START] = rsp[RSP_START];
    b[BTN_DU]    = rsp[RSP_DU];
    b[BTN_DD]    = rsp[RSP_DD];
    b[BTN_DL]    = rsp[RSP_DL];
    b[BTN_DR]    = rsp[RSP_DR];
    b[BTN_L]     = rsp[RSP_L];
    b[BTN_R]     = rsp[RSP_R];
    b[BTN_CU]    = rsp[RSP_CU];
    b[BTN_CD]    = rsp[RSP_CD];
    return b;
  endfunction

endpackage

// File: rtl/n64_sync.sv
// Two-flop synchronizer for the pad level, plus a delayed copy for edge pulses.
// Resets to the idle-high line level so no spurious edge follows reset.
module n64_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d,
  output logic lvl,
  output logic fall,
  output logic rise
);

  logic [2:0] q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q <= 3'b111;
    else         q <= {q[1:0], d};
  end

  assign lvl  = q[1];
  assign fall = q[2] & ~q[1];
  assign rise = ~q[2] & q[1];

endmodule

// File: rtl/n64_poll_engine.sv
// N64 controller poll engine: sends 0x01, decodes the 32-bit reply by pulse width,
// and publishes 12 button bits.
//
// state           | meaning
// IDLE            | poll period timer running, line released
// TX_BIT          | sending command cell bit_q (MSB first)
// TX_STOP         | 1 us low stop bit
// RX_WAIT_FALL    | waiting for start of a response cell
// RX_SAMPLE       | 2 us after the falling edge, then sample level
// RX_WAIT_RISE    | waiting for the line to return high
// DONE            | publish buttons once the line is high
// ABORT           | one-cycle timeout pulse
module n64_poll_engine
  import n64_pkg::*;
#(
  parameter int CLK_PER_US     = 14,
  parameter int POLL_PERIOD_US = 16000,
  parameter int RX_TIMEOUT_US  = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        n64_i,
  output logic        n64_oe_o,
  output logic [11:0] buttons_o,
  output logic        valid_o,
  output logic        timeout_o,
  output logic        busy_o
);

  localparam int CELL_CYC = 4 * CLK_PER_US;
  localparam int TO_CYC   = RX_TIMEOUT_US * CLK_PER_US;
  localparam int POLL_CYC = POLL_PERIOD_US * CLK_PER_US;
  localparam int CNT_MAX  = (CELL_CYC > TO_CYC) ? CELL_CYC : TO_CYC;
  localparam int CNT_W    = $clog2(CNT_MAX);
  localparam int POLL_W   = $clog2(POLL_CYC);

  localparam logic [CNT_W-1:0]  CELL_END = CNT_W'(CELL_CYC - 1);
  localparam logic [CNT_W-1:0]  US_END   = CNT_W'(CLK_PER_US - 1);
  localparam logic [CNT_W-1:0]  SMP_END  = CNT_W'(2 * CLK_PER_US - 1);
  localparam logic [CNT_W-1:0]  TO_END   = CNT_W'(TO_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0]  LOW_1    = CNT_W'(CLK_PER_US);
  localparam logic [CNT_W-1:0]  LOW_0    = CNT_W'(3 * CLK_PER_US);
  localparam logic [POLL_W-1:0] POLL_END = POLL_W'(POLL_CYC - 1);
  localparam logic [5:0]        BITS_ALL = 6'(RESP_BITS);

  n64_state_t           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [POLL_W-1:0]    poll_q;
  logic [5:0]           bit_q;
  logic [RESP_BITS-1:0] rsp_q;
  logic [11:0]          btn_q;
  logic [7:0]           cmd;
  logic                 rx_lvl, rx_fall, rx_rise, rx_high;
  logic                 cell_end, smp_end, tx_bit;

  n64_sync u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d      (n64_i),
    .lvl    (rx_lvl),
    .fall   (rx_fall),
    .rise   (rx_rise)
  );

  assign cmd      = POLL_CMD;
  assign rx_high  = rx_lvl | rx_rise;
  assign cell_end = (state_q == ST_TX_BIT) && (cnt_q == CELL_END);
  assign smp_end  = (state_q == ST_RX_SAMPLE) && (cnt_q == SMP_END);
  assign tx_bit   = cmd[~bit_q[2:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:         if (poll_q == POLL_END) state_d = ST_TX_BIT;
      ST_TX_BIT:       if (cell_end && bit_q == 6'd7) state_d = ST_TX_STOP;
      ST_TX_STOP:      if (cnt_q == US_END) state_d = ST_RX_WAIT_FALL;
      ST_RX_WAIT_FALL: begin
        if (rx_fall)              state_d = ST_RX_SAMPLE;
        else if (cnt_q == TO_END) state_d = ST_ABORT;
      end
      ST_RX_SAMPLE:    if (smp_end) state_d = ST_RX_WAIT_RISE;
      ST_RX_WAIT_RISE: begin
        if (rx_high)              state_d = (bit_q == BITS_ALL) ? ST_DONE : ST_RX_WAIT_FALL;
        else if (cnt_q == TO_END) state_d = ST_ABORT;
      end
      ST_DONE: begin
        if (rx_high)              state_d = ST_IDLE;
        else if (cnt_q == TO_END) state_d = ST_ABORT;
      end
      ST_ABORT:        state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  // Phase counter restarts on every state change and at each command cell boundary.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      poll_q <= '0;
      bit_q  <= '0;
      rsp_q  <= '0;
      btn_q  <= '0;
    end else begin
      if (state_d != state_q || cell_end) cnt_q <= '0;
      else if (cnt_q != CNT_SAT)          cnt_q <= cnt_q + 1'b1;

      if (state_q != ST_IDLE || state_d != ST_IDLE) poll_q <= '0;
      else if (poll_q != POLL_END)                  poll_q <= poll_q + 1'b1;

      if (state_q == ST_IDLE || state_q == ST_TX_STOP) bit_q <= '0;
      else if (cell_end || smp_end)                    bit_q <= bit_q + 1'b1;

      if (smp_end) rsp_q <= {rx_lvl, rsp_q[RESP_BITS-1:1]};

      if (state_q == ST_DONE && rx_high) btn_q <= map_buttons(rsp_q);
    end
  end

  always_comb begin
    n64_oe_o  = 1'b0;
    valid_o   = 1'b0;
    timeout_o = 1'b0;
    busy_o    = (state_q != ST_IDLE);
    case (state_q)
      ST_TX_BIT:  n64_oe_o  = (cnt_q < (tx_bit ? LOW_1 : LOW_0));
      ST_TX_STOP: n64_oe_o  = 1'b1;
      ST_DONE:    valid_o   = rx_high;
      ST_ABORT:   timeout_o = 1'b1;
      default:    n64_oe_o  = 1'b0;
    endcase
  end

  assign buttons_o = btn_q;

endmodule

// File: tb/tb_n64_poll_engine.sv
// Bench for n64_poll_engine: open-drain pad model with a behavioural controller
// that answers polls with randomized pulse widths.
`timescale 1ns/100ps
module tb_n64_poll_engine;

  localparam int CPU  = 14;
  localparam int PP   = 10;
  localparam int TOUS = 8;
  localparam int CELL = 4 * CPU;
  localparam int PCYC = PP * CPU;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ctl_low = 1'b0;
  logic        n64_i;
  logic        n64_oe;
  logic [11:0] buttons;
  logic        valid, timeout, busy;

  int n_vec = 0;
  int n_bad = 0;
  int valid_cnt = 0;
  int to_cnt = 0;

  assign n64_i = ~(n64_oe | ctl_low);

  always #5 clk = ~clk;

  n64_poll_engine #(
    .CLK_PER_US     (CPU),
    .POLL_PERIOD_US (PP),
    .RX_TIMEOUT_US  (TOUS)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .n64_i     (n64_i),
    .n64_oe_o  (n64_oe),
    .buttons_o (buttons),
    .valid_o   (valid),
    .timeout_o (timeout),
    .busy_o    (busy)
  );

  always @(negedge clk) begin
    if (valid)   valid_cnt++;
    if (timeout) to_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // r[k] is the k-th bit sent by the controller.
  function automatic logic [11:0] ref_buttons(input logic [31:0] r);
    return {r[0], r[1], r[2], r[3], r[4], r[5], r[6], r[7], r[10], r[11], r[12], r[13]};
  endfunction

  function automatic logic [31:0] pack_bytes(input logic [7:0] b0, b1, b2, b3);
    logic [31:0] r;
    logic [31:0] w;
    w = {b0, b1, b2, b3};
    for (int k = 0; k < 32; k++) r[k] = w[31-k];
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_poll_start(output int n);
    n = 0;
    while (!n64_oe && n < 4 * PCYC) begin
      tick;
      n++;
    end
  endtask

  task automatic wait_release(output bit ok);
    int  nf = 0;
    int  g  = 0;
    bit  prev = 1'b1;
    while (nf < 9 && g < 1000) begin
      tick;
      g++;
      if (prev && !n64_oe) nf++;
      prev = n64_oe;
    end
    ok = (nf == 9);
  endtask

  task automatic drive_bit(input int low);
    ctl_low = 1'b1;
    repeat (low) tick;
    ctl_low = 1'b0;
    repeat (CELL - low) tick;
  endtask

  task automatic run_poll(input string tag, input logic [31:0] r, input int nbits,
                          input int l1a, input int l1b, input int l0a, input int l0b,
                          input bit stuck);
    int n;
    bit ok;
    wait_poll_start(n);
    if (n >= 4 * PCYC) begin
      check({tag, "_poll_start"}, 32'(n), 32'(PCYC));
      return;
    end
    wait_release(ok);
    if (!ok) begin
      check({tag, "_release"}, 0, 1);
      return;
    end
    repeat (28) tick;
    if (stuck) begin
      ctl_low = 1'b1;
      n = 0;
      while (!timeout && n < 400) begin
        tick;
        n++;
      end
      // fall seen 2 cycles in, 2 us sample, then 8 us rise timeout
      check({tag, "_abort_delay_ok"}, 32'(n >= 140 && n <= 147), 1);
      ctl_low = 1'b0;
      tick;
      check({tag, "_busy_after_abort"}, 32'(busy), 0);
      n = 1;
      while (!n64_oe && n < 4 * PCYC) begin
        tick;
        n++;
      end
      check({tag, "_next_poll_delay"}, 32'(n), 32'(PCYC + 1));
      return;
    end
    for (int k = 0; k < nbits; k++)
      drive_bit(r[k] ? int'($urandom_range(l1b, l1a)) : int'($urandom_range(l0b, l0a)));
    if (nbits == 32) begin
      ctl_low = 1'b1;
      repeat (CPU) tick;
      ctl_low = 1'b0;
    end
    n = 0;
    while (busy && n < 4000) begin
      tick;
      n++;
    end
    check({tag, "_busy_low"}, 32'(busy), 0);
  endtask

  initial begin
    int          n, v0, t0, mism, lowc, lowexp;
    logic [7:0]  cmd;
    logic [31:0] r;
    logic [11:0] prev;

    cmd = 8'h01;
    repeat (3) @(negedge clk);
    check("rst_oe", 32'(n64_oe), 0);
    check("rst_buttons", 32'(buttons), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_busy", 32'(busy), 0);

    @(negedge clk) rst_n = 1'b1;
    n = 0;
    while (!n64_oe && n < 4 * PCYC) begin
      tick;
      n++;
    end
    check("first_poll_cycles", 32'(n), 32'(PCYC));
    check("busy_in_tx", 32'(busy), 1);

    mism = 0;
    for (int i = 0; i < 8; i++) begin
      lowexp = cmd[7-i] ? CPU : 3 * CPU;
      lowc = 0;
      for (int c = 0; c < CELL; c++) begin
        if (n64_oe) lowc++;
        if (n64_oe !== (c < lowexp)) mism++;
        tick;
      end
      check($sformatf("tx_cell%0d_low", i), 32'(lowc), 32'(lowexp));
    end
    for (int c = 0; c < CPU; c++) begin
      if (n64_oe !== 1'b1) mism++;
      tick;
    end
    check("tx_wave_mismatches", 32'(mism), 0);
    check("tx_released", 32'(n64_oe), 0);
    n = 0;
    while (!timeout && n < 400) begin
      tick;
      n++;
    end
    check("nores_timeout_delay", 32'(n), 32'(TOUS * CPU));
    check("nores_buttons", 32'(buttons), 0);
    check("nores_no_valid", 32'(valid_cnt), 0);
    tick;
    check("nores_busy_low", 32'(busy), 0);

    // nominal good response
    r = pack_bytes(8'h90, 8'h00, 8'h7F, 8'h80);
    v0 = valid_cnt; t0 = to_cnt;
    run_poll("good", r, 32, CPU, CPU, 3 * CPU, 3 * CPU, 1'b0);
    check("good_buttons", 32'(buttons), 32'h900);
    check("good_model", 32'(buttons), 32'(ref_buttons(r)));
    check("good_valid", 32'(valid_cnt - v0), 1);
    check("good_no_timeout", 32'(to_cnt - t0), 0);

    // truncated response keeps prior buttons
    prev = buttons;
    v0 = valid_cnt; t0 = to_cnt;
    run_poll("trunc", $urandom, 16, CPU, CPU, 3 * CPU, 3 * CPU, 1'b0);
    check("trunc_timeout", 32'(to_cnt - t0), 1);
    check("trunc_no_valid", 32'(valid_cnt - v0), 0);
    check("trunc_buttons_held", 32'(buttons), 32'(prev));

    // pulse-width boundary: 1.5 us low is a 1, 2.5 us low is a 0
    r = pack_bytes(8'h00, 8'h38, 8'h00, 8'h00);
    v0 = valid_cnt;
    run_poll("bound", r, 32, 21, 21, 35, 35, 1'b0);
    check("bound_buttons", 32'(buttons), 32'h00E);
    check("bound_valid", 32'(valid_cnt - v0), 1);

    for (int it = 0; it < 5; it++) begin
      r = $urandom;
      v0 = valid_cnt; t0 = to_cnt;
      run_poll($sformatf("rand%0d", it), r, 32, 10, 24, 34, 46, 1'b0);
      check($sformatf("rand%0d_buttons", it), 32'(buttons), 32'(ref_buttons(r)));
      check($sformatf("rand%0d_valid", it), 32'(valid_cnt - v0), 1);
      check($sformatf("rand%0d_no_timeout", it), 32'(to_cnt - t0), 0);
    end

    prev = buttons;
    v0 = valid_cnt; t0 = to_cnt;
    run_poll("stuck", 32'h0, 0, CPU, CPU, 3 * CPU, 3 * CPU, 1'b1);
    check("stuck_timeout", 32'(to_cnt - t0), 1);
    check("stuck_no_valid", 32'(valid_cnt - v0), 0);
    check("stuck_buttons_held", 32'(buttons), 32'(prev));

    // reset while driving the first command cell low
    check("mid_tx_oe_high", 32'(n64_oe), 1);
    repeat (3) tick;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_oe", 32'(n64_oe), 0);
    check("midrst_buttons", 32'(buttons), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_valid", 32'(valid), 0);
    check("midrst_timeout", 32'(timeout), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!n64_oe && n < 4 * PCYC) begin
      tick;
      n++;
    end
    check("midrst_first_poll", 32'(n), 32'(PCYC));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
